// File: rtl/mem_arbiter.sv
// Main-memory line arbiter: serialises icache refills and dcache refills/writebacks onto one
// request/fill interface and steers each returning fill back to the client that owns it.
module mem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH    = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned STORE_LATENCY    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ic_req,
    input  logic [ADDRESS_WIDTH-1:0]    ic_addr,
    input  logic                        dc_req,
    input  logic                        dc_store,
    input  logic [ADDRESS_WIDTH-1:0]    dc_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] dc_evict_data,
    output logic                        ic_fill,
    output logic                        dc_fill,
    output logic                        dc_store_done,
    output logic [CACHE_LINE_WIDTH-1:0] fill_data,
    output logic                        mem_req,
    output logic                        mem_req_store,
    output logic [ADDRESS_WIDTH-1:0]    mem_req_address,
    output logic [CACHE_LINE_WIDTH-1:0] mem_req_evict_data,
    input  logic                        mem_fill,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_fill_data,
    input  logic [ADDRESS_WIDTH-1:0]    mem_fill_address
);

    localparam int unsigned LOFF  = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int unsigned CNT_W = (STORE_LATENCY > 0) ? $clog2(STORE_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitFill,
        StWaitStore,
        StResp
    } state_e;

    state_e             state_q;
    logic               last_grant_q;  // 0 = icache, 1 = dcache
    logic               owner_q;
    logic               store_q;
    logic [CNT_W-1:0]   store_cnt_q;
    logic               grant_dc;
    logic               fill_match;
    logic               unused_fill_offset;

    // On a tie the client that was not granted last time wins.
    always_comb begin
        grant_dc = dc_req && (!ic_req || !last_grant_q);
    end

    // Only the line part of the fill address identifies the transaction.
    assign fill_match = mem_fill_address[ADDRESS_WIDTH-1:LOFF] ==
                        mem_req_address[ADDRESS_WIDTH-1:LOFF];
    assign unused_fill_offset = ^mem_fill_address[LOFF-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= StIdle;
            last_grant_q       <= 1'b0;
            owner_q            <= 1'b0;
            store_q            <= 1'b0;
            store_cnt_q        <= '0;
            ic_fill            <= 1'b0;
            dc_fill            <= 1'b0;
            dc_store_done      <= 1'b0;
            fill_data          <= '0;
            mem_req            <= 1'b0;
            mem_req_store      <= 1'b0;
            mem_req_address    <= '0;
            mem_req_evict_data <= '0;
        end else begin
            ic_fill       <= 1'b0;
            dc_fill       <= 1'b0;
            dc_store_done <= 1'b0;
            mem_req       <= 1'b0;
            mem_req_store <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ic_req || dc_req) begin
                        owner_q            <= grant_dc;
                        last_grant_q       <= grant_dc;
                        store_q            <= grant_dc && dc_store;
                        mem_req            <= 1'b1;
                        mem_req_store      <= grant_dc && dc_store;
                        mem_req_address    <= grant_dc ? dc_addr : ic_addr;
                        mem_req_evict_data <= grant_dc ? dc_evict_data : '0;
                        state_q            <= StIssue;
                    end
                end
                StIssue: begin
                    if (store_q) begin
                        store_cnt_q <= CNT_W'(STORE_LATENCY);
                        state_q     <= StWaitStore;
                    end else begin
                        state_q <= StWaitFill;
                    end
                end
                StWaitFill: begin
                    if (mem_fill && fill_match) begin
                        fill_data <= mem_fill_data;
                        ic_fill   <= !owner_q;
                        dc_fill   <= owner_q;
                        state_q   <= StResp;
                    end
                end
                StWaitStore: begin
                    if (store_cnt_q == '0) begin
                        dc_store_done <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        store_cnt_q <= store_cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory answers requests, expected client
// responses are queued as stimulus is driven and popped as pulses appear.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam int unsigned SL = 4;
    localparam logic [1:0] KIC = 2'd0;
    localparam logic [1:0] KDC = 2'd1;
    localparam logic [1:0] KST = 2'd2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          dc_req = 1'b0;
    logic          dc_store = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [LW-1:0] dc_evict_data = '0;
    logic          ic_fill, dc_fill, dc_store_done;
    logic [LW-1:0] fill_data;
    logic          mem_req, mem_req_store;
    logic [AW-1:0] mem_req_address;
    logic [LW-1:0] mem_req_evict_data;
    logic          mem_fill = 1'b0;
    logic [LW-1:0] mem_fill_data = '0;
    logic [AW-1:0] mem_fill_address = '0;

    mem_arbiter #(
        .ADDRESS_WIDTH   (AW),
        .CACHE_LINE_WIDTH(LW),
        .STORE_LATENCY   (SL)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ic_req            (ic_req),
        .ic_addr           (ic_addr),
        .dc_req            (dc_req),
        .dc_store          (dc_store),
        .dc_addr           (dc_addr),
        .dc_evict_data     (dc_evict_data),
        .ic_fill           (ic_fill),
        .dc_fill           (dc_fill),
        .dc_store_done     (dc_store_done),
        .fill_data         (fill_data),
        .mem_req           (mem_req),
        .mem_req_store     (mem_req_store),
        .mem_req_address   (mem_req_address),
        .mem_req_evict_data(mem_req_evict_data),
        .mem_fill          (mem_fill),
        .mem_fill_data     (mem_fill_data),
        .mem_fill_address  (mem_fill_address)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    kind;
        logic [LW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    function automatic void expect_resp(input logic [1:0] k, input logic [LW-1:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        logic [AW-1:0] la;
        la = a & ~AW'(32'hF);
        return {4{la ^ 32'h5A5A_0000}};
    endfunction

    // Memory model state
    logic [LW-1:0] mem_arr [logic [AW-1:0]];
    bit            mem_auto = 1'b1;
    int unsigned   mem_delay = 3;
    bit            pend = 1'b0;
    int unsigned   pend_cnt = 0;
    logic [AW-1:0] pend_addr = '0;
    int unsigned   inj_req = 0;
    int unsigned   inj_seen = 0;
    logic [AW-1:0] inj_addr = '0;
    logic [LW-1:0] inj_data = '0;

    // Request log and pulse count
    int unsigned   n_memreq = 0;
    int unsigned   n_pulse = 0;
    int unsigned   last_req_cyc = 0;
    logic [AW-1:0] last_req_addr = '0;
    logic          last_req_store = 1'b0;
    logic [LW-1:0] last_req_data = '0;

    function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
        logic [AW-1:0] la;
        la = a & ~AW'(32'hF);
        if (mem_arr.exists(la)) return mem_arr[la];
        return init_line(la);
    endfunction

    always @(negedge clk) begin
        logic [1:0] kind;
        exp_t       e;
        mem_fill = 1'b0;
        if (inj_req != inj_seen) begin
            inj_seen         = inj_req;
            mem_fill         = 1'b1;
            mem_fill_address = inj_addr;
            mem_fill_data    = inj_data;
        end else if (mem_auto && pend) begin
            if (pend_cnt <= 1) begin
                mem_fill         = 1'b1;
                mem_fill_address = pend_addr;
                mem_fill_data    = mem_rd(pend_addr);
                pend             = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (reset_n && mem_req) begin
            n_memreq++;
            last_req_cyc   = cyc;
            last_req_addr  = mem_req_address;
            last_req_store = mem_req_store;
            last_req_data  = mem_req_evict_data;
            if (mem_req_store) begin
                mem_arr[mem_req_address & ~AW'(32'hF)] = mem_req_evict_data;
            end else if (mem_auto) begin
                pend      = 1'b1;
                pend_cnt  = mem_delay;
                pend_addr = mem_req_address;
            end
        end
        if (reset_n && (ic_fill || dc_fill || dc_store_done)) begin
            n_pulse++;
            kind = ic_fill ? KIC : (dc_fill ? KDC : KST);
            check_eq("one_hot_pulse", LW'({ic_fill, dc_fill, dc_store_done}),
                     LW'(kind == KIC ? 3'b100 : (kind == KDC ? 3'b010 : 3'b001)));
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", LW'(exp_q.size()), LW'(1));
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_kind", LW'(kind), LW'(e.kind));
                if (e.kind != KST) check_eq("fill_data", fill_data, e.data);
            end
        end
    end

    task automatic ic_read(input logic [AW-1:0] a, output int unsigned t_req,
                           output int unsigned t_done);
        bit seen;
        seen    = 1'b0;
        ic_addr = a;
        ic_req  = 1'b1;
        t_req   = cyc;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (ic_fill) seen = 1'b1;
        end
        ic_req = 1'b0;
        t_done = cyc;
        check_eq("ic_done_seen", LW'(seen), LW'(1));
    endtask

    task automatic dc_op(input logic st, input logic [AW-1:0] a, input logic [LW-1:0] d,
                         output int unsigned t_req, output int unsigned t_done);
        bit seen;
        seen          = 1'b0;
        dc_store      = st;
        dc_addr       = a;
        dc_evict_data = d;
        dc_req        = 1'b1;
        t_req         = cyc;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (dc_fill || dc_store_done) seen = 1'b1;
        end
        dc_req = 1'b0;
        t_done = cyc;
        check_eq("dc_done_seen", LW'(seen), LW'(1));
    endtask

    task automatic inject_fill(input logic [AW-1:0] a, input logic [LW-1:0] d);
        inj_addr = a;
        inj_data = d;
        inj_req++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pulses"}, LW'({ic_fill, dc_fill, dc_store_done}), '0);
        check_eq({tag, "_mem_req"}, LW'({mem_req, mem_req_store}), '0);
        check_eq({tag, "_address"}, LW'(mem_req_address), '0);
        check_eq({tag, "_evict"}, mem_req_evict_data, '0);
        check_eq({tag, "_fill_data"}, fill_data, '0);
    endtask

    initial begin
        int unsigned   t0, t1, t2, t3, t4, t5, nreq, npul;
        logic [LW-1:0] a5, yline;
        a5    = {16{8'hA5}};
        yline = {4{32'hFEED_0104}};

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        reset_n = 1'b1;

        // Stale fill in IDLE must be ignored
        @(posedge clk); #1 inject_fill(32'h40, a5);
        repeat (3) @(posedge clk);
        #1 check_eq("idle_fill_ignored", LW'(n_pulse), LW'(0));

        // Single icache read, D = 3
        nreq = n_memreq;
        expect_resp(KIC, init_line(32'h40));
        ic_read(32'h40, t0, t1);
        check_eq("rd_req_cycle", LW'(last_req_cyc - t0), LW'(1));
        check_eq("rd_req_addr", LW'(last_req_addr), LW'(32'h40));
        check_eq("rd_req_store", LW'(last_req_store), LW'(0));
        check_eq("rd_done_cycle", LW'(t1 - t0), LW'(2 + mem_delay));
        check_eq("rd_one_req", LW'(n_memreq - nreq), LW'(1));
        repeat (3) @(posedge clk);
        #1 check_eq("fill_data_hold", fill_data, init_line(32'h40));

        // Tie after reset goes to dcache; dcache re-requesting while icache waits is a new tie
        expect_resp(KDC, init_line(32'h300));
        expect_resp(KIC, init_line(32'h200));
        expect_resp(KDC, init_line(32'h340));
        @(posedge clk); #1;
        fork
            ic_read(32'h200, t0, t1);
            begin
                dc_op(1'b0, 32'h300, '0, t2, t3);
                @(posedge clk); #1;
                dc_op(1'b0, 32'h340, '0, t4, t5);
            end
        join
        check_eq("tie1_dc_first", LW'(t3 < t1), LW'(1));
        check_eq("tie2_ic_first", LW'(t1 < t5), LW'(1));

        // Write-then-read
        @(posedge clk); #1;
        expect_resp(KST, '0);
        dc_op(1'b1, 32'h80, a5, t0, t1);
        check_eq("st_req_store", LW'(last_req_store), LW'(1));
        check_eq("st_req_addr", LW'(last_req_addr), LW'(32'h80));
        check_eq("st_req_data", last_req_data, a5);
        check_eq("st_done_cycle", LW'(t1 - t0), LW'(SL + 3));
        @(posedge clk); #1;
        expect_resp(KIC, a5);
        ic_read(32'h80, t2, t3);
        check_eq("rd_after_st_order", LW'(last_req_cyc > t1), LW'(1));

        // Wrong fill ignored, same-line fill accepted
        mem_auto = 1'b0;
        @(posedge clk); #1;
        fork
            ic_read(32'h100, t0, t1);
            begin
                npul = n_pulse;
                repeat (3) @(posedge clk);
                #1 inject_fill(32'h140, a5);
                repeat (4) @(posedge clk);
                #1 check_eq("wrong_fill_no_pulse", LW'(n_pulse - npul), LW'(0));
                expect_resp(KIC, yline);
                inject_fill(32'h104, yline);
            end
        join

        // Reset during WAIT_FILL
        @(posedge clk); #1;
        ic_addr = 32'h180;
        ic_req  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1 check_all_zero("midop_reset");
        ic_req = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        npul = n_pulse;
        inject_fill(32'h180, a5);
        repeat (4) @(posedge clk);
        #1 check_eq("late_fill_no_pulse", LW'(n_pulse - npul), LW'(0));
        mem_auto = 1'b1;
        expect_resp(KDC, init_line(32'h1C0));
        dc_op(1'b0, 32'h1C0, '0, t0, t1);
        check_eq("post_reset_done_cycle", LW'(t1 - t0), LW'(2 + mem_delay));

        repeat (3) @(posedge clk);
        #1 check_eq("scoreboard_empty", LW'(exp_q.size()), LW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
